dec_scan_sequencer: RTL

//   Upstream address/enable generator for the 5-to-32 line decoder. On a start request it

---
 rtl/dec_scan_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dec_scan_sequencer.sv
// Address/enable sequencer feeding a 5-to-32 line decoder: walks 1..32 lines up or down with wrap.
// Latency: start sampled in IDLE, first line enabled on the following cycle; outputs are registered.
// Backpressure: none; start is ignored outside IDLE (no queuing), abort ends a run on the next cycle.
module dec_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] start_addr,
  input  logic [5:0] len,
  input  logic       dir_down,
  input  logic       abort,
  output logic [4:0] addr,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_FIN} state_t;

  // Last-cycle markers for the dwell/gap counters; GAP=0 never enters S_GAP.
  localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_LAST_I);

  state_t     state, state_nxt;
  logic [7:0] dwell_cnt, gap_cnt;
  logic [5:0] remaining;
  logic [4:0] addr_q;
  logic       dir_q;
  logic       aborted_q;

  logic       dwell_last, gap_last, run_req;
  logic [4:0] addr_step;
  logic [5:0] len_clamped;

  assign dwell_last  = (dwell_cnt == DWELL_LAST);
  assign gap_last    = (gap_cnt == GAP_LAST);
  assign run_req     = start && !abort;
  assign addr_step   = dir_q ? (addr_q - 5'd1) : (addr_q + 5'd1);
  assign len_clamped = (len > 6'd32) ? 6'd32 : len;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort outranks normal progress in ACTIVE/GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run_req) state_nxt = (len == 6'd0) ? S_FIN : S_ACTIVE;
      end
      S_ACTIVE: begin
        if (abort) state_nxt = S_IDLE;
        else if (dwell_last) begin
          if (remaining == 6'd1) state_nxt = S_FIN;
          else if (GAP > 0)      state_nxt = S_GAP;
          else                   state_nxt = S_ACTIVE;
        end
      end
      S_GAP: begin
        if (abort)         state_nxt = S_IDLE;
        else if (gap_last) state_nxt = S_ACTIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping: latched run parameters, dwell/gap counters, address stepping, abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 5'd0;
      dir_q     <= 1'b0;
      remaining <= 6'd0;
      dwell_cnt <= 8'd0;
      gap_cnt   <= 8'd0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run_req && len != 6'd0) begin
            addr_q    <= start_addr;
            dir_q     <= dir_down;
            remaining <= len_clamped;
            dwell_cnt <= 8'd0;
            gap_cnt   <= 8'd0;
          end
        end
        S_ACTIVE: begin
          if (abort) begin
            aborted_q <= 1'b1;
            dwell_cnt <= 8'd0;
            remaining <= 6'd0;
          end else if (dwell_last) begin
            dwell_cnt <= 8'd0;
            remaining <= remaining - 6'd1;
            // Back-to-back lines step straight away when there is no gap.
            if (GAP == 0 && remaining != 6'd1) addr_q <= addr_step;
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (abort) begin
            aborted_q <= 1'b1;
            gap_cnt   <= 8'd0;
            remaining <= 6'd0;
          end else if (gap_last) begin
            gap_cnt <= 8'd0;
            addr_q  <= addr_step;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; en is high solely in ACTIVE.
  always_comb begin
    addr    = addr_q;
    en      = (state == S_ACTIVE);
    busy    = (state == S_ACTIVE) || (state == S_GAP);
    done    = (state == S_FIN);
    aborted = aborted_q;
  end

endmodule
